regfile_wb_queue: RTL

Write-side companion to the 16×32 register file. Collects result writes from execution units into a small in-order FIFO and drains one entry per cycle into the register file's single write port (RegWrite/Rw/RFin). When bypass is compiled in, the two read ports see pending writes, so a read never returns a stale value while a write is still queued. Sits between the execute/completion stage and RegFiles in the pipelined core.

---
 rtl/regfile_wb_queue_pkg.sv | 19 +
 rtl/regfile_wb_queue_if.sv | 20 ++
 rtl/regfile_wb_queue_fwd_match.sv | 45 ++++
 rtl/regfile_wb_queue.sv | 112 +++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// regfile_wb_queue_pkg: types and constants shared by the write-back queue
// and the neighbouring pipeline stages.
//   WBQ_AW / WBQ_DW : register address / data widths of the 16x32 register file
//   REG_LINK/REG_PC : architectural link and program-counter register numbers
//   wbq_entry_t     : one pending register-file write {rw, data}
package regfile_wb_queue_pkg;

  localparam int WBQ_AW = 4;
  localparam int WBQ_DW = 32;

  localparam logic [WBQ_AW-1:0] REG_LINK = 4'd14;
  localparam logic [WBQ_AW-1:0] REG_PC   = 4'd15;

  typedef struct packed {
    logic [WBQ_AW-1:0] rw;
    logic [WBQ_DW-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: enqueue handshake from the completion stage.
//   in_valid : producer has a write to enqueue
//   in_ready : queue can accept this cycle
//   in_rw    : destination register
//   in_data  : result value
// master = producer, slave = write-back queue.
interface regfile_wb_queue_if #(
  parameter int AW = 4,
  parameter int DW = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rw;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_rw, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rw, input in_data, output in_ready);

endinterface

// File: rtl/regfile_wb_queue_fwd_match.sv
// wbq_fwd_match: searches the pending-write array for a register address and
// returns the youngest matching entry.
//   ents  : queue storage, indexed by slot
//   vmask : per-slot valid bits
//   head  : slot of the oldest entry
//   count : queue occupancy
//   addr  : register address being read
//   hit   : a pending write to addr exists
//   data  : value of the youngest such write
module wbq_fwd_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW
) (
  input  wbq_entry_t                 ents [DEPTH],
  input  logic [DEPTH-1:0]           vmask,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              addr,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PW'(head + PW'(k));
      if ((CW'(k) < count) && vmask[idx] && (ents[idx].rw == addr)) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order FIFO of pending register-file writes, drained
// one entry per cycle into the register file's single write port.
//   clk, Reset        : clock, asynchronous active-low reset
//   enq (slave)       : enqueue handshake (in_valid/in_ready/in_rw/in_data)
//   wb_en             : register file may be written this cycle
//   flush             : synchronous discard of all queued writes
//   RegWrite/Rw/RFin  : register-file write port
//   Ra/Rb, RFout1/2   : register-file read addresses and raw read data
//   rd1/rd2           : read data after bypass
//   count/empty/full  : occupancy
// Optional feature: define WBQ_BYPASS_EN to forward pending writes onto
// rd1/rd2; otherwise the raw read data passes straight through.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WBQ_DW,
  parameter int AW    = WBQ_AW
) (
  input  logic                   clk,
  input  logic                   Reset,
  regfile_wb_queue_if.slave      enq,
  input  logic                   wb_en,
  input  logic                   flush,
  output logic                   RegWrite,
  output logic [AW-1:0]          Rw,
  output logic [DW-1:0]          RFin,
  input  logic [AW-1:0]          Ra,
  input  logic [AW-1:0]          Rb,
  input  logic [DW-1:0]          RFout1,
  input  logic [DW-1:0]          RFout2,
  output logic [DW-1:0]          rd1,
  output logic [DW-1:0]          rd2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          do_enq;

  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  // No fall-through: a full queue refuses input even while draining.
  assign enq.in_ready = !full && !flush;
  assign do_enq       = enq.in_valid && enq.in_ready;
  assign RegWrite     = !empty && wb_en && !flush;
  assign Rw           = mem[head].rw;
  assign RFin         = mem[head].data;
  assign count        = cnt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) begin
        mem[tail] <= '{rw: enq.in_rw, data: enq.in_data};
        tail      <= tail + 1'b1;
      end
      if (RegWrite) head <= head + 1'b1;
      if (do_enq && !RegWrite)      cnt <= cnt + 1'b1;
      else if (!do_enq && RegWrite) cnt <= cnt - 1'b1;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0] vmask;
  logic             hit1;
  logic             hit2;
  logic [DW-1:0]    fwd1;
  logic [DW-1:0]    fwd2;

  // Slot i is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    vmask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      vmask[i] = CW'(PW'(i - head)) < cnt;
  end

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .ents(mem), .vmask(vmask), .head(head), .count(cnt), .addr(Ra),
    .hit(hit1), .data(fwd1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .ents(mem), .vmask(vmask), .head(head), .count(cnt), .addr(Rb),
    .hit(hit2), .data(fwd2)
  );

  assign rd1 = hit1 ? fwd1 : RFout1;
  assign rd2 = hit2 ? fwd2 : RFout2;
`else
  logic unused_raddr;
  assign unused_raddr = ^{Ra, Rb};
  assign rd1 = RFout1;
  assign rd2 = RFout2;
`endif

endmodule
